// File: rtl/cic_comb_decim.sv
// cic_comb_decim: decimating CIC comb chain with 2-entry AXI-Stream output FIFO.
// Define CIC_COMB_ROUND_EN for round-half-up with positive saturation (adds one stage of latency).
module cic_comb_decim #(
  parameter int IN_WIDTH  = 48,
  parameter int OUT_WIDTH = 16,
  parameter int DECIM     = 256,
  parameter int N_STAGES  = 1
) (
  input  logic                 clk,
  input  logic                 sync_reset,
  input  logic                 s_axis_tvalid,
  input  logic [IN_WIDTH-1:0]  s_axis_tdata,
  output logic                 s_axis_tready,
  output logic                 m_axis_tvalid,
  output logic [OUT_WIDTH-1:0] m_axis_tdata,
  input  logic                 m_axis_tready,
  output logic                 overflow
);
  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  logic [CW-1:0]        r_cnt;
  logic                 w_keep;
  logic [IN_WIDTH-1:0]  r_x [0:N_STAGES];
  logic [IN_WIDTH-1:0]  r_z [0:N_STAGES-1];
  logic [N_STAGES:0]    r_v;
  logic [OUT_WIDTH-1:0] w_fmt;
  logic                 w_fv;
  logic [OUT_WIDTH-1:0] r_mem [0:1];
  logic                 r_wp;
  logic                 r_rp;
  logic [1:0]           r_fcnt;
  logic                 r_ovf;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_push;
  assign s_axis_tready = !sync_reset;
  assign w_keep = s_axis_tvalid && (r_cnt == '0);
  // r_x[0] is the kept-sample register; r_x[i+1] holds the difference of stage i.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_cnt <= '0;
      r_v <= '0;
      for (int i = 0; i <= N_STAGES; i++) r_x[i] <= '0;
      for (int i = 0; i < N_STAGES; i++) r_z[i] <= '0;
    end else begin
      if (s_axis_tvalid) r_cnt <= (r_cnt == CW'(DECIM - 1)) ? '0 : r_cnt + 1'b1;
      r_v <= {r_v[N_STAGES-1:0], w_keep};
      if (w_keep) r_x[0] <= s_axis_tdata;
      for (int i = 0; i < N_STAGES; i++)
        if (r_v[i]) begin
          r_z[i] <= r_x[i];
          r_x[i+1] <= r_x[i] - r_z[i];
        end
    end
  end
`ifdef CIC_COMB_ROUND_EN
  logic [OUT_WIDTH-1:0] w_top;
  logic                 w_half;
  logic [OUT_WIDTH-1:0] r_rnd;
  logic                 r_rv;
  assign w_top  = r_x[N_STAGES][IN_WIDTH-1 -: OUT_WIDTH];
  assign w_half = r_x[N_STAGES][IN_WIDTH-OUT_WIDTH-1];
  // A carry into the sign bit can only happen from max positive, which is then held.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_rnd <= '0;
      r_rv <= 1'b0;
    end else begin
      r_rv <= r_v[N_STAGES];
      if (r_v[N_STAGES])
        r_rnd <= (w_top == {1'b0, {(OUT_WIDTH-1){1'b1}}}) ? w_top : w_top + OUT_WIDTH'(w_half);
    end
  end
  assign w_fmt = r_rnd;
  assign w_fv  = r_rv;
`else
  assign w_fmt = r_x[N_STAGES][IN_WIDTH-1 -: OUT_WIDTH];
  assign w_fv  = r_v[N_STAGES];
`endif
  assign w_pop  = m_axis_tvalid && m_axis_tready;
  assign w_full = (r_fcnt == 2'd2);
  assign w_push = w_fv && (!w_full || w_pop);
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp <= 1'b0;
      r_rp <= 1'b0;
      r_fcnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= w_fmt;
        r_wp <= !r_wp;
      end
      if (w_pop) r_rp <= !r_rp;
      r_fcnt <= r_fcnt + {1'b0, w_push} - {1'b0, w_pop};
      if (w_fv && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end
  assign m_axis_tvalid = (r_fcnt != '0);
  assign m_axis_tdata  = m_axis_tvalid ? r_mem[r_rp] : '0;
  assign overflow      = r_ovf;
endmodule

// File: tb/tb_cic_comb_decim.sv
// tb_cic_comb_decim: directed bench with a DECIM=4 instance and a DECIM=1 instance.
module tb_cic_comb_decim;
  logic        clk = 1'b0;
  logic        rst;
  logic        d4_tv, d4_trdy, d4_mv, d4_mr, d4_ovf;
  logic [47:0] d4_td;
  logic [15:0] d4_md;
  logic        d1_tv, d1_trdy, d1_mv, d1_mr, d1_ovf;
  logic [47:0] d1_td;
  logic [15:0] d1_md;
  int n_checks = 0;
  int n_fail = 0;
`ifdef CIC_COMB_ROUND_EN
  localparam int LAT = 3;
  localparam logic [15:0] HALF_EXP = 16'h0001;
`else
  localparam int LAT = 2;
  localparam logic [15:0] HALF_EXP = 16'h0000;
`endif

  always #5 clk = ~clk;

  cic_comb_decim #(.IN_WIDTH(48), .OUT_WIDTH(16), .DECIM(4), .N_STAGES(1)) u_d4 (
    .clk(clk), .sync_reset(rst),
    .s_axis_tvalid(d4_tv), .s_axis_tdata(d4_td), .s_axis_tready(d4_trdy),
    .m_axis_tvalid(d4_mv), .m_axis_tdata(d4_md), .m_axis_tready(d4_mr),
    .overflow(d4_ovf));

  cic_comb_decim #(.IN_WIDTH(48), .OUT_WIDTH(16), .DECIM(1), .N_STAGES(1)) u_d1 (
    .clk(clk), .sync_reset(rst),
    .s_axis_tvalid(d1_tv), .s_axis_tdata(d1_td), .s_axis_tready(d1_trdy),
    .m_axis_tvalid(d1_mv), .m_axis_tdata(d1_md), .m_axis_tready(d1_mr),
    .overflow(d1_ovf));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    d4_tv = 1'b0;
    d1_tv = 1'b0;
    tick;
    rst = 1'b0;
  endtask

  task automatic wait_d1(output bit found);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (d1_mv) found = 1'b1;
      else tick;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    d4_tv = 1'b0; d4_td = '0; d4_mr = 1'b1;
    d1_tv = 1'b0; d1_td = '0; d1_mr = 1'b1;
    tick;
    n_checks++; if (d4_trdy !== 1'b0) begin n_fail++; $display("FAIL rst_d4_tready got %b exp 0", d4_trdy); end
    n_checks++; if (d1_trdy !== 1'b0) begin n_fail++; $display("FAIL rst_d1_tready got %b exp 0", d1_trdy); end
    n_checks++; if (d4_mv !== 1'b0) begin n_fail++; $display("FAIL rst_d4_tvalid got %b exp 0", d4_mv); end
    n_checks++; if (d4_md !== 16'h0) begin n_fail++; $display("FAIL rst_d4_tdata got %h exp 0000", d4_md); end
    n_checks++; if (d4_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_d4_ovf got %b exp 0", d4_ovf); end
    n_checks++; if (d1_mv !== 1'b0) begin n_fail++; $display("FAIL rst_d1_tvalid got %b exp 0", d1_mv); end
    n_checks++; if (d1_md !== 16'h0) begin n_fail++; $display("FAIL rst_d1_tdata got %h exp 0000", d1_md); end
    n_checks++; if (d1_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_d1_ovf got %b exp 0", d1_ovf); end
    rst = 1'b0;
    #1;
    n_checks++; if (d4_trdy !== 1'b1) begin n_fail++; $display("FAIL run_d4_tready got %b exp 1", d4_trdy); end
    n_checks++; if (d1_trdy !== 1'b1) begin n_fail++; $display("FAIL run_d1_tready got %b exp 1", d1_trdy); end
  endtask

  task automatic test_stream;
    int gi[$];
    logic [15:0] gd[$];
    int ei[4];
    logic [15:0] ed[4];
    ei = '{LAT, LAT + 4, LAT + 8, LAT + 12};
    ed = '{16'h0000, 16'h0004, 16'h0004, 16'h0004};
    do_reset;
    d4_mr = 1'b1;
    for (int c = 0; c < 22; c++) begin
      d4_tv = (c < 13);
      d4_td = 48'(c) << 32;
      tick;
      if (d4_mv) begin gi.push_back(c); gd.push_back(d4_md); end
    end
    d4_tv = 1'b0;
    n_checks++; if (gi.size() !== 4) begin n_fail++; $display("FAIL stream_count got %0d exp 4", gi.size()); end
    for (int i = 0; i < 4 && i < gi.size(); i++) begin
      n_checks++; if (gd[i] !== ed[i]) begin n_fail++; $display("FAIL stream_data[%0d] got %h exp %h", i, gd[i], ed[i]); end
      n_checks++; if (gi[i] !== ei[i]) begin n_fail++; $display("FAIL stream_cycle[%0d] got %0d exp %0d", i, gi[i], ei[i]); end
    end
  endtask

  task automatic test_toggle;
    int gi[$];
    logic [15:0] gd[$];
    int ei[4];
    logic [15:0] ed[4];
    ei = '{LAT, LAT + 8, LAT + 16, LAT + 24};
    ed = '{16'h0000, 16'h0004, 16'h0004, 16'h0004};
    do_reset;
    d4_mr = 1'b1;
    for (int c = 0; c < 30; c++) begin
      d4_tv = (c % 2 == 0) && (c < 26);
      d4_td = 48'(c / 2) << 32;
      tick;
      if (d4_mv) begin gi.push_back(c); gd.push_back(d4_md); end
    end
    d4_tv = 1'b0;
    n_checks++; if (gi.size() !== 4) begin n_fail++; $display("FAIL toggle_count got %0d exp 4", gi.size()); end
    for (int i = 0; i < 4 && i < gi.size(); i++) begin
      n_checks++; if (gd[i] !== ed[i]) begin n_fail++; $display("FAIL toggle_data[%0d] got %h exp %h", i, gd[i], ed[i]); end
      n_checks++; if (gi[i] !== ei[i]) begin n_fail++; $display("FAIL toggle_cycle[%0d] got %0d exp %0d", i, gi[i], ei[i]); end
    end
  endtask

  task automatic test_wrap;
    logic [15:0] gd[$];
    do_reset;
    d1_mr = 1'b1;
    for (int c = 0; c < 8; c++) begin
      d1_tv = (c < 2);
      d1_td = (c == 0) ? 48'h7FFF_FFFF_FFFF : 48'h8001_0000_0003;
      tick;
      if (d1_mv) gd.push_back(d1_md);
    end
    d1_tv = 1'b0;
    n_checks++; if (gd.size() !== 2) begin n_fail++; $display("FAIL wrap_count got %0d exp 2", gd.size()); end
    if (gd.size() >= 2) begin
      n_checks++; if (gd[0] !== 16'h7FFF) begin n_fail++; $display("FAIL wrap_first got %h exp 7fff", gd[0]); end
      n_checks++; if (gd[1] !== 16'h0001) begin n_fail++; $display("FAIL wrap_second got %h exp 0001", gd[1]); end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] gd[$];
    logic [47:0] cum[4];
    cum = '{48'd1, 48'd3, 48'd6, 48'd10};
    do_reset;
    d1_mr = 1'b0;
    for (int c = 0; c < 10; c++) begin
      d1_tv = (c < 4);
      d1_td = cum[c % 4] << 32;
      tick;
      if (c < LAT) begin
        n_checks++; if (d1_mv !== 1'b0) begin n_fail++; $display("FAIL bp_early_valid c=%0d got %b exp 0", c, d1_mv); end
      end else begin
        n_checks++; if (d1_mv !== 1'b1 || d1_md !== 16'h0001) begin n_fail++; $display("FAIL bp_hold c=%0d got v=%b d=%h exp v=1 d=0001", c, d1_mv, d1_md); end
      end
    end
    d1_tv = 1'b0;
    n_checks++; if (d1_ovf !== 1'b1) begin n_fail++; $display("FAIL bp_overflow got %b exp 1", d1_ovf); end
    d1_mr = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (d1_mv) gd.push_back(d1_md);
      tick;
    end
    n_checks++; if (gd.size() !== 2) begin n_fail++; $display("FAIL bp_drain_count got %0d exp 2", gd.size()); end
    if (gd.size() >= 2) begin
      n_checks++; if (gd[0] !== 16'h0001) begin n_fail++; $display("FAIL bp_drain0 got %h exp 0001", gd[0]); end
      n_checks++; if (gd[1] !== 16'h0002) begin n_fail++; $display("FAIL bp_drain1 got %h exp 0002", gd[1]); end
    end
    n_checks++; if (d1_ovf !== 1'b1) begin n_fail++; $display("FAIL bp_sticky got %b exp 1", d1_ovf); end
  endtask

  task automatic test_reset_mid;
    int seen;
    bit found;
    seen = 0;
    d1_mr = 1'b1;
    for (int c = 0; c < 20 && seen < 3; c++) begin
      d1_tv = 1'b1;
      d1_td = 48'(c + 1) << 32;
      tick;
      if (d1_mv) seen++;
    end
    n_checks++; if (seen !== 3) begin n_fail++; $display("FAIL mid_outputs got %0d exp 3", seen); end
    rst = 1'b1;
    tick;
    n_checks++; if (d1_mv !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b exp 0", d1_mv); end
    n_checks++; if (d1_ovf !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ovf got %b exp 0", d1_ovf); end
    n_checks++; if (d1_md !== 16'h0) begin n_fail++; $display("FAIL mid_rst_data got %h exp 0000", d1_md); end
    rst = 1'b0;
    d1_td = 48'h1234_0000_0000;
    tick;
    d1_tv = 1'b0;
    wait_d1(found);
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL mid_post_timeout got %b exp 1", found); end
    n_checks++; if (d1_md !== 16'h1234) begin n_fail++; $display("FAIL mid_post_data got %h exp 1234", d1_md); end
  endtask

  task automatic test_round;
    bit found;
    do_reset;
    d1_mr = 1'b1;
    d1_tv = 1'b1;
    d1_td = 48'h0000_8000_0000;
    tick;
    d1_tv = 1'b0;
    wait_d1(found);
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL round_half_timeout got %b exp 1", found); end
    n_checks++; if (d1_md !== HALF_EXP) begin n_fail++; $display("FAIL round_half got %h exp %h", d1_md, HALF_EXP); end
    do_reset;
    d1_tv = 1'b1;
    d1_td = 48'h7FFF_8000_0000;
    tick;
    d1_tv = 1'b0;
    wait_d1(found);
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL round_sat_timeout got %b exp 1", found); end
    n_checks++; if (d1_md !== 16'h7FFF) begin n_fail++; $display("FAIL round_sat got %h exp 7fff", d1_md); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_stream;
    test_toggle;
    test_wrap;
    test_backpressure;
    test_reset_mid;
    test_round;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
